fb_write_arbiter: RTL and testbench

// Shares the write ports of the 16-bank frame buffer (16 x blockram, 320x15 px each,
// 320x240 frame) between two pixel producers: req0 = Mandelbrot/pattern engine,
// req1 = UART com_to_mem loader. Round-robin arbitration on a valid/ready handshake.

---
 rtl/fb_write_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbiter that maps (x,y) pixels from two producers onto a 16-bank frame buffer write port
// Ports: clk, rst (async, active-high), i_enable (clock enable),
//   req{0,1}_valid/ready/x/y/data (valid/ready pixel producers),
//   o_we (one-hot bank write enable), o_addr/o_data (shared write bus),
//   o_drop_cnt (saturating out-of-range count), o_frame_done (last-pixel pulse).
module fb_write_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 12,
  parameter int H_PIX      = 320,
  parameter int LINES_BANK = 15,
  parameter int N_BANKS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8:0]            req0_x,
  input  logic [7:0]            req0_y,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8:0]            req1_x,
  input  logic [7:0]            req1_y,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic [N_BANKS-1:0]    o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [7:0]            o_drop_cnt,
  output logic                  o_frame_done
);
  localparam int V_PIX = LINES_BANK * N_BANKS;
  localparam int BW    = $clog2(N_BANKS);
  logic                  last_q, last_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [8:0]            s1_x_q, s1_x_d;
  logic [7:0]            s1_y_q, s1_y_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [7:0]            drop_q, drop_d;
  logic [N_BANKS-1:0]    we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  fd_q, fd_d;
  logic                  grant0, grant1, xfer, in_range;
  logic [8:0]            mx;
  logic [7:0]            my;
  logic [DATA_WIDTH-1:0] md;
  logic [BW-1:0]         bank;
  logic [7:0]            row;
  logic [ADDR_WIDTH-1:0] row_w;
  // last_q=1 means req1 won last, so req0 gets priority out of reset
  assign grant0     = req0_valid & (~req1_valid | last_q);
  assign grant1     = req1_valid & ~grant0;
  assign req0_ready = i_enable & grant0;
  assign req1_ready = i_enable & grant1;
  assign xfer       = req0_ready | req1_ready;
  assign mx         = req1_ready ? req1_x : req0_x;
  assign my         = req1_ready ? req1_y : req0_y;
  assign md         = req1_ready ? req1_data : req0_data;
  assign in_range   = (mx < 9'(H_PIX)) && (my < 8'(V_PIX));
  // bank = y / LINES_BANK as a compare chain, avoiding a divider
  always_comb begin
    bank = '0;
    for (int k = 1; k < N_BANKS; k++) bank = (s1_y_q >= 8'(k * LINES_BANK)) ? bank + 1'b1 : bank;
  end
  assign row   = s1_y_q - 8'(32'(bank) * LINES_BANK);
  assign row_w = ADDR_WIDTH'(row);
  always_comb begin
    last_d     = last_q;
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_data_d  = s1_data_q;
    drop_d     = drop_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    fd_d       = fd_q;
    if (i_enable) begin
      last_d     = req1_ready ? 1'b1 : req0_ready ? 1'b0 : last_q;
      s1_valid_d = xfer & in_range;
      s1_x_d     = xfer ? mx : s1_x_q;
      s1_y_d     = xfer ? my : s1_y_q;
      s1_data_d  = xfer ? md : s1_data_q;
      drop_d     = (xfer && !in_range && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      we_d       = s1_valid_q ? N_BANKS'(1) << bank : '0;
      // row*320 as two shifts; bus keeps its last value between writes
      addr_d     = s1_valid_q ? (row_w << 8) + (row_w << 6) + ADDR_WIDTH'(s1_x_q) : addr_q;
      data_d     = s1_valid_q ? s1_data_q : data_q;
      fd_d       = s1_valid_q && s1_x_q == 9'(H_PIX - 1) && s1_y_q == 8'(V_PIX - 1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_data_q  <= '0;
      drop_q     <= '0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      fd_q       <= 1'b0;
    end else begin
      last_q     <= last_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_data_q  <= s1_data_d;
      drop_q     <= drop_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      fd_q       <= fd_d;
    end
  end
  // a held write stays registered while disabled and issues once on re-enable
  assign o_we         = we_q & {N_BANKS{i_enable}};
  assign o_frame_done = fd_q & i_enable;
  assign o_addr       = addr_q;
  assign o_data       = data_q;
  assign o_drop_cnt   = drop_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: randomized and directed checks of fb_write_arbiter against a pixel-level reference model
module tb_fb_write_arbiter;
  logic        clk = 1'b0, rst = 1'b1, i_enable = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [8:0]  req0_x = '0, req1_x = '0;
  logic [7:0]  req0_y = '0, req1_y = '0;
  logic [11:0] req0_data = '0, req1_data = '0;
  logic [15:0] o_we;
  logic [12:0] o_addr;
  logic [11:0] o_data;
  logic [7:0]  o_drop_cnt;
  logic        o_frame_done;
  fb_write_arbiter dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_data(req1_data),
    .o_we(o_we), .o_addr(o_addr), .o_data(o_data), .o_drop_cnt(o_drop_cnt), .o_frame_done(o_frame_done)
  );
  always #5 clk = ~clk;
  typedef struct {int bank; int addr; int data; bit fd; int cnt;} wr_t;
  wr_t q[$];
  int  gseq[$];
  int  total = 0, bad = 0, drop_m = 0;
  bit  last_m = 1'b1, x0 = 1'b0, x1 = 1'b0;
  int  px, py, pd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // arbitration and write expectations, sampled mid-cycle
  initial forever begin
    bit g0, g1;
    logic [15:0] exp_we;
    @(negedge clk);
    if (!rst) begin
      g0 = i_enable && req0_valid && (!req1_valid || last_m);
      g1 = i_enable && req1_valid && (!req0_valid || !last_m);
      check("rdy0", req0_ready, g0);
      check("rdy1", req1_ready, g1);
      x0 = g0;
      x1 = g1;
      px = g1 ? req1_x : req0_x;
      py = g1 ? req1_y : req0_y;
      pd = g1 ? req1_data : req0_data;
      if (g0 || g1) gseq.push_back(g1 ? 1 : 0);
      exp_we = (q.size() > 0 && q[0].cnt == 0 && i_enable) ? 16'(1 << q[0].bank) : 16'h0;
      check("we", o_we, exp_we);
      if (exp_we != 0) begin
        check("addr", o_addr, q[0].addr);
        check("data", o_data, q[0].data);
        check("fdone", o_frame_done, q[0].fd);
      end else check("fdone_idle", o_frame_done, 0);
      check("drop", o_drop_cnt, drop_m);
    end
  end
  // a transfer is written two enabled clock edges after it is accepted
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      last_m = 1'b1;
      drop_m = 0;
      x0 = 1'b0;
      x1 = 1'b0;
    end else if (i_enable) begin
      if (q.size() > 0 && q[0].cnt == 0) void'(q.pop_front());
      foreach (q[i]) q[i].cnt = q[i].cnt - 1;
      if (x0 || x1) begin
        if (px < 320 && py < 240)
          q.push_back('{bank: py / 15, addr: (py % 15) * 320 + px, data: pd, fd: (px == 319 && py == 239), cnt: 1});
        else if (drop_m < 255) drop_m++;
      end
      if (x0) last_m = 1'b0;
      if (x1) last_m = 1'b1;
    end
  end
  task automatic put(input int r, input int x, input int y, input int d);
    bit ok = 0;
    if (r == 0) begin req0_x = 9'(x); req0_y = 8'(y); req0_data = 12'(d); req0_valid = 1'b1; end
    else begin req1_x = 9'(x); req1_y = 8'(y); req1_data = 12'(d); req1_valid = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (r == 0) ? req0_ready : req1_ready;
    end
    if (!ok) check("put_timeout", 0, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", o_we, 0);
    check("rst_addr", o_addr, 0);
    check("rst_data", o_data, 0);
    check("rst_drop", o_drop_cnt, 0);
    check("rst_fd", o_frame_done, 0);
    rst = 1'b0;
    put(0, 0, 0, 'hABC);
    @(negedge clk) check("t1_early", o_we, 0);
    @(negedge clk) check("t1_we", o_we, 16'h0001);
    check("t1_addr", o_addr, 0);
    check("t1_data", o_data, 12'hABC);
    @(negedge clk) check("t1_once", o_we, 0);
    @(posedge clk);
    #1;
    put(0, 5, 14, 1);
    put(0, 7, 15, 2);
    @(negedge clk) check("t2a_we", o_we, 16'h0001);
    check("t2a_addr", o_addr, 4485);
    @(negedge clk) check("t2b_we", o_we, 16'h0002);
    check("t2b_addr", o_addr, 7);
    @(posedge clk);
    #1;
    put(1, 319, 239, 'hFFF);
    @(negedge clk);
    @(negedge clk) check("t3_we", o_we, 16'h8000);
    check("t3_addr", o_addr, 4799);
    check("t3_fd", o_frame_done, 1);
    @(posedge clk);
    #1;
    do_reset();
    gseq.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_x = 1; req0_y = 1; req1_x = 100; req1_y = 100;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (x0) req0_x = req0_x + 1;
      if (x1) req1_x = req1_x + 1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t4_n", gseq.size(), 6);
    for (int i = 0; i < 6 && i < gseq.size(); i++) check("t4_seq", gseq[i], i % 2);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    put(0, 320, 0, 3);
    put(0, 0, 240, 4);
    repeat (3) @(negedge clk);
    check("t5_drop2", o_drop_cnt, 2);
    @(posedge clk);
    #1;
    req0_x = 400;
    req0_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_sat", o_drop_cnt, 255);
    @(posedge clk);
    #1;
    put(0, 10, 20, 5);
    put(0, 11, 20, 6);
    rst = 1'b1;
    #1;
    check("t6_we", o_we, 0);
    check("t6_addr", o_addr, 0);
    check("t6_data", o_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk) check("t6_nowe", o_we, 0);
    @(posedge clk);
    #1;
    put(0, 3, 30, 7);
    i_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_enable = 1'b1;
    n = 0;
    repeat (6) @(negedge clk) if (o_we != 0) n++;
    check("t7_once", n, 1);
    @(posedge clk);
    #1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      i_enable = ($urandom % 8) != 0;
      if (!req0_valid || x0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_x = 9'($urandom_range(0, 330));
        req0_y = 8'($urandom_range(0, 250));
        req0_data = 12'($urandom);
      end
      if (!req1_valid || x1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_x = 9'($urandom_range(0, 330));
        req1_y = 8'($urandom_range(0, 250));
        req1_data = 12'($urandom);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    i_enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
